// File: rtl/cache_assoc.sv
// N-way set-associative cache storage with true-LRU replacement and write-back flags.
// One lookup/command per cycle; the response is registered and shows the target
// way's contents from before that cycle's write.
module cache_assoc #(
  parameter int unsigned WORD_BITS        = 32,
  parameter int unsigned ADDR_BITS        = 32,
  parameter int unsigned WORD_BYTES_WIDTH = 2,
  parameter int unsigned LINE_WORDS_WIDTH = 2,
  parameter int unsigned LINE_INDEX_WIDTH = 5,
  parameter int unsigned WAY_WIDTH        = 1,
  parameter int unsigned TAG_BITS         = ADDR_BITS - LINE_INDEX_WIDTH - LINE_WORDS_WIDTH - WORD_BYTES_WIDTH
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          en,
  input  logic [ADDR_BITS-1:0]                          addr,
  input  logic                                          store,
  input  logic                                          edit,
  input  logic                                          invalid,
  input  logic [WORD_BITS-1:0]                          din,
  output logic                                          resp_valid,
  output logic                                          hit,
  output logic [((WAY_WIDTH > 0) ? WAY_WIDTH : 1)-1:0]  way,
  output logic [WORD_BITS-1:0]                          dout,
  output logic                                          valid,
  output logic                                          dirty,
  output logic [TAG_BITS-1:0]                           tag
);

  localparam int unsigned WAYS       = 1 << WAY_WIDTH;
  localparam int unsigned SETS       = 1 << LINE_INDEX_WIDTH;
  localparam int unsigned LINE_WORDS = 1 << LINE_WORDS_WIDTH;
  localparam int unsigned WW         = (WAY_WIDTH > 0) ? WAY_WIDTH : 1;
  localparam int unsigned IDX_LSB    = WORD_BYTES_WIDTH + LINE_WORDS_WIDTH;

  // Storage: flags and ages are reset, data and tags are not.
  logic                 valid_q [WAYS][SETS];
  logic                 dirty_q [WAYS][SETS];
  logic [TAG_BITS-1:0]  tag_q   [WAYS][SETS];
  logic [WORD_BITS-1:0] data_q  [WAYS][SETS][LINE_WORDS];
  logic [WW-1:0]        age_q   [SETS][WAYS];

  logic [LINE_INDEX_WIDTH-1:0] set_idx;
  logic [LINE_WORDS_WIDTH-1:0] word_idx;
  logic [TAG_BITS-1:0]         req_tag;
  logic                        unused_bits;

  logic          hit_c;
  logic [WW-1:0] hit_way;
  logic [WW-1:0] victim;
  logic          free_found;
  logic [WW-1:0] target;
  logic [WW-1:0] old_age;
  logic          do_inv;
  logic          do_store;
  logic          do_edit;
  logic          do_lru;

  assign set_idx     = addr[IDX_LSB +: LINE_INDEX_WIDTH];
  assign word_idx    = addr[WORD_BYTES_WIDTH +: LINE_WORDS_WIDTH];
  assign req_tag     = addr[ADDR_BITS-1 -: TAG_BITS];
  assign unused_bits = ^addr[WORD_BYTES_WIDTH-1:0];

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit_c   = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][set_idx] && (tag_q[w][set_idx] == req_tag)) begin
        hit_c   = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  // Victim: lowest invalid way, otherwise the oldest way.
  always_comb begin
    victim     = '0;
    free_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!free_found && !valid_q[w][set_idx]) begin
        victim     = WW'(w);
        free_found = 1'b1;
      end
    end
    if (!free_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[set_idx][w] == WW'(WAYS - 1)) begin
          victim = WW'(w);
        end
      end
    end
  end

  // Target selection and command decode (invalid > store > edit).
  always_comb begin
    target   = hit_c ? hit_way : victim;
    old_age  = age_q[set_idx][target];
    do_inv   = en & invalid & hit_c;
    do_store = en & store & ~invalid;
    do_edit  = en & edit & ~store & ~invalid & hit_c;
    do_lru   = en & ~invalid & (hit_c | store);
  end

  // Valid/dirty flags of the target way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
        end
      end
    end else if (do_inv) begin
      valid_q[target][set_idx] <= 1'b0;
      dirty_q[target][set_idx] <= 1'b0;
    end else if (do_store) begin
      valid_q[target][set_idx] <= 1'b1;
      dirty_q[target][set_idx] <= 1'b0;
    end else if (do_edit) begin
      dirty_q[target][set_idx] <= 1'b1;
    end
  end

  // True-LRU ages: accessed way becomes youngest, younger ways age by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WW'(w);
        end
      end
    end else if (do_lru) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WW'(w) == target) begin
          age_q[set_idx][w] <= '0;
        end else if (age_q[set_idx][w] < old_age) begin
          age_q[set_idx][w] <= age_q[set_idx][w] + WW'(1);
        end
      end
    end
  end

  // Data and tag arrays hold through reset; a request coinciding with reset is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst) begin
      if (do_store) begin
        data_q[target][set_idx][word_idx] <= din;
        tag_q[target][set_idx]            <= req_tag;
      end else if (do_edit) begin
        data_q[target][set_idx][word_idx] <= din;
      end
    end
  end

  // Registered response built from pre-write contents of the target way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      hit        <= 1'b0;
      way        <= '0;
      dout       <= '0;
      valid      <= 1'b0;
      dirty      <= 1'b0;
      tag        <= '0;
    end else begin
      resp_valid <= en;
      if (en) begin
        hit   <= hit_c;
        way   <= target;
        dout  <= data_q[target][set_idx][word_idx];
        valid <= valid_q[target][set_idx];
        dirty <= dirty_q[target][set_idx];
        tag   <= tag_q[target][set_idx];
      end
    end
  end

endmodule

// File: doc/cache_assoc.md
# cache_assoc

Parametrised N-way set-associative cache storage array with true-LRU replacement, a write-back successor to the direct-mapped cache store. The block holds tag, valid, dirty, per-set LRU state and word data. It resolves hit/way/victim for each request, applies one store/edit/invalid command per cycle, and returns a registered response one cycle later. It sits between the CPU-side cache controller FSM and the memory refill/write-back path.

## Interface
- WORD_BITS, 32, data word width
- ADDR_BITS, 32, byte address width
- WORD_BYTES_WIDTH, 2, log2 bytes per word
- LINE_WORDS_WIDTH, 2, log2 words per line
- LINE_INDEX_WIDTH, 5, log2 sets
- WAY_WIDTH, 1, log2 ways (WAYS = 2^WAY_WIDTH, 1..8 ways)
- TAG_BITS, ADDR_BITS-LINE_INDEX_WIDTH-LINE_WORDS_WIDTH-WORD_BYTES_WIDTH (23), tag width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- en  in  1  request strobe; commands ignored when 0
- addr  in  ADDR_BITS  byte address: tag | set index | word offset | byte offset
- store  in  1  fill: write din, set valid=1, dirty=0, tag=addr tag
- edit  in  1  write hit: write din, set dirty=1
- invalid  in  1  clear valid and dirty of hit way
- din  in  WORD_BITS  write data
- resp_valid  out  1  response fields valid (registered en)
- hit  out  1  request hit (registered)
- way  out  WAY_WIDTH  hit way if hit, else victim way
- dout  out  WORD_BITS  addressed word of selected way (old contents)
- valid, dirty  out  1 each  flags of selected way (old contents)
- tag  out  TAG_BITS  tag of selected way; on miss with dirty=1, write-back address tag

## Operation
- Lookup (combinational, pre-write state): set = addr index; hit_w = valid & tag match per way; at most one way matches (store never creates duplicates).
- Victim: lowest-index invalid way; if none, way whose age == WAYS-1.
- Target way: hit way if hit, else victim.
- Command priority: invalid > store > edit; lower ones ignored when higher asserted.
- store: writes target way (hit way on hit, victim on miss); data word at addr offset = din; valid=1, dirty=0, tag updated.
- edit: hit only; word = din, dirty=1. Edit on miss: no state change.
- invalid: hit only; valid=0, dirty=0, data/tag untouched, LRU unchanged. Miss: no change.
- LRU: per set, per way age of WAY_WIDTH bits forming a permutation of 0..WAYS-1. On en with hit and no invalid, or any store: target age -> 0; ways with age < old target age increment; others hold. Plain read hit counts as access. Read miss without store: no change.
- Response: dout/valid/dirty/tag always reflect the target way before the write of that cycle, so the controller receives victim data/tag for write-back.
- WAY_WIDTH=0: direct-mapped, age logic degenerates, victim = way 0.

## Timing
- Request accepted at edge where en=1; response registered at that same edge and visible the following cycle; latency 1, throughput 1 request/cycle, no stall.
- Writes commit at the request edge; a request the next cycle to the same line sees new contents (no forwarding hazard).
- resp_valid = en delayed one cycle; other outputs hold last value when en=0.
- Reset (async, any time): valid=0 and dirty=0 for all lines; age[set][w]=w; resp_valid=0, hit=0, way=0, dout=0, valid=0, dirty=0, tag=0. Data and tag arrays not reset. Request in flight at reset is dropped; no partial write.
- Simultaneous store+edit same cycle: store semantics (dirty=0).

## Test plan
- Reset then read addr 0x00001004 -> next cycle resp_valid=1, hit=0, way=0, valid=0, dirty=0.
- store din=0xDEADBEEF at 0x00001004, then read -> hit=1, way=0, dout=0xDEADBEEF, dirty=0; edit din=0x12345678 then read -> dout=0x12345678, dirty=1.
- WAYS=2: store 0x00001000 (way0), store 0x00011000 (way1), read 0x00001000, store 0x00021000 -> victim way=1, response tag=0x00011000's tag, valid=1; subsequent read 0x00011000 hit=0.
- Dirty eviction: edit line in way0, make way0 LRU, store new tag same set -> response way=0, dirty=1, tag=old tag, dout=edited word.
- edit or invalid on miss -> no change (subsequent read of resident lines unchanged); invalid on hit -> read hit=0, valid=0, next store fills that way.
- Assert rst asynchronously mid-cycle with en=1, store=1 -> outputs 0 immediately, all lines invalid, ages reset, store not committed.
